// File: rtl/sd_spi_responder_if.sv
// sd_spi_responder_if
//   Bundles the serial SPI link and the external block-memory port of the
//   SPI-mode SD responder.
//   Signals:
//     mosi       host-to-card serial data (idles high)
//     miso       card-to-host serial data (idles high)
//     mem_addr   memory word address
//     mem_re     one-cycle read strobe
//     mem_rdata  read data, valid the cycle after mem_re
//     mem_we     one-cycle write strobe
//     mem_wdata  write data, qualified by mem_we
//   Modports:
//     master  host/memory side (drives mosi and mem_rdata)
//     slave   responder side (drives miso and the memory request signals)
interface sd_spi_responder_if #(
    parameter int ADDR_W = 16
);
    logic              mosi;
    logic              miso;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [63:0]       mem_rdata;
    logic              mem_we;
    logic [63:0]       mem_wdata;

    modport master (
        output mosi,
        input  miso,
        input  mem_addr,
        input  mem_re,
        output mem_rdata,
        input  mem_we,
        input  mem_wdata
    );

    modport slave (
        input  mosi,
        output miso,
        output mem_addr,
        output mem_re,
        input  mem_rdata,
        output mem_we,
        output mem_wdata
    );
endinterface

// File: rtl/sd_spi_responder.sv
// sd_spi_responder
//   Card-side SPI-mode SD responder serving single-block (64-bit) CMD17
//   reads and CMD24 writes, backed by an external synchronous 64-bit memory.
//   One bit moves per clk on mosi/miso, MSB first.
//   Ports:
//     clk  single clock; mosi sampled and miso updated on its rising edge
//     rst  asynchronous, active-high reset
//     bus  sd_spi_responder_if.slave: mosi/miso link plus memory port
//   Parameters:
//     ADDR_W      block-address width (memory depth 2^ADDR_W words)
//     NCR         idle 0xFF bytes between command end bit and R1 (1..8)
//     NAC         idle bytes between R1 and the read start token (1..8)
//     BUSY_BYTES  zero bytes of busy after the write data response (1..8)
//     TOKEN_TO    cycles to wait for the write start token
module sd_spi_responder #(
    parameter int ADDR_W     = 16,
    parameter int NCR        = 1,
    parameter int NAC        = 1,
    parameter int BUSY_BYTES = 2,
    parameter int TOKEN_TO   = 256
) (
    input logic              clk,
    input logic              rst,
    sd_spi_responder_if.slave bus
);

    localparam int CNT_W = ($clog2(TOKEN_TO + 1) > 7) ? $clog2(TOKEN_TO + 1) : 7;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_NCR,
        S_RESP,
        S_NAC,
        S_RD_TOK,
        S_RD_DATA,
        S_RD_CRC,
        S_WR_WAIT,
        S_WR_DATA,
        S_WR_CRC,
        S_WR_RESP,
        S_WR_BUSY
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [46:0]       cmd_sr;     // frame bits received so far, newest in bit 0
    logic [6:0]        crc7;
    logic [7:0]        tx_byte;    // R1, read token or data response being shifted out
    logic              cmd_ok;
    logic              is_read;
    logic              re_q;
    logic [63:0]       rdata_q;
    logic [63:0]       dsr;        // read data out / write data in
    logic [15:0]       crc16;
    logic [15:0]       crc_sr;     // read CRC out / write CRC in
    logic              wr_ok;

    logic              miso_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_re_q;
    logic              mem_we_q;
    logic [63:0]       mem_wdata_q;

    assign bus.miso      = miso_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = b ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // Full frame as seen on the edge that samples the end bit.
    logic [47:0] frame;
    logic [31:0] f_arg;
    logic        arg_in_range;
    logic [7:0]  r1_next;

    assign frame        = {cmd_sr, bus.mosi};
    assign f_arg        = frame[39:8];
    assign arg_in_range = ((64'(f_arg)) >> ADDR_W) == 64'd0;

    always_comb begin
        r1_next = 8'h00;
        if (frame[47] || !frame[46] || !frame[0] || (frame[7:1] != crc7)) begin
            r1_next = 8'h08;
        end else if ((frame[45:40] != 6'd17) && (frame[45:40] != 6'd24)) begin
            r1_next = 8'h04;
        end else if (!arg_in_range) begin
            r1_next = 8'h20;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            cmd_sr      <= '0;
            crc7        <= '0;
            tx_byte     <= '1;
            cmd_ok      <= 1'b0;
            is_read     <= 1'b0;
            re_q        <= 1'b0;
            rdata_q     <= '0;
            dsr         <= '0;
            crc16       <= '0;
            crc_sr      <= '0;
            wr_ok       <= 1'b0;
            miso_q      <= 1'b1;
            mem_addr_q  <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            // Memory returns data the cycle after the strobe; capture it then.
            re_q     <= mem_re_q;
            if (re_q) begin
                rdata_q <= bus.mem_rdata;
            end

            case (state)
                S_IDLE: begin
                    miso_q <= 1'b1;
                    cmd_sr <= {cmd_sr[45:0], bus.mosi};
                    cnt    <= '0;
                    crc7   <= '0;   // start bit 0 leaves a zero-init CRC unchanged
                    if (!bus.mosi) begin
                        state <= S_CMD;
                    end
                end

                S_CMD: begin
                    miso_q <= 1'b1;
                    cmd_sr <= {cmd_sr[45:0], bus.mosi};
                    // cnt 0..38 carries frame bits 46..8, the CRC7 coverage
                    if (cnt <= CNT_W'(38)) begin
                        crc7 <= crc7_step(crc7, bus.mosi);
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(46)) begin
                        state   <= S_NCR;
                        cnt     <= '0;
                        tx_byte <= r1_next;
                        cmd_ok  <= (r1_next == 8'h00);
                        is_read <= (frame[45:40] == 6'd17);
                        if (r1_next == 8'h00) begin
                            mem_addr_q <= f_arg[ADDR_W-1:0];
                        end
                    end
                end

                S_NCR: begin
                    miso_q <= 1'b1;
                    if ((cnt == '0) && cmd_ok && is_read) begin
                        mem_re_q <= 1'b1;
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(8 * NCR - 1)) begin
                        state <= S_RESP;
                        cnt   <= '0;
                    end
                end

                S_RESP: begin
                    miso_q  <= tx_byte[7];
                    tx_byte <= {tx_byte[6:0], 1'b1};
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(7)) begin
                        cnt <= '0;
                        if (!cmd_ok) begin
                            state <= S_IDLE;
                        end else if (is_read) begin
                            state <= S_NAC;
                        end else begin
                            state <= S_WR_WAIT;
                        end
                    end
                end

                S_NAC: begin
                    miso_q <= 1'b1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(8 * NAC - 1)) begin
                        state   <= S_RD_TOK;
                        cnt     <= '0;
                        tx_byte <= 8'hFE;
                    end
                end

                S_RD_TOK: begin
                    miso_q  <= tx_byte[7];
                    tx_byte <= {tx_byte[6:0], 1'b1};
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(7)) begin
                        state <= S_RD_DATA;
                        cnt   <= '0;
                        dsr   <= rdata_q;
                        crc16 <= '0;
                    end
                end

                S_RD_DATA: begin
                    miso_q <= dsr[63];
                    dsr    <= {dsr[62:0], 1'b0};
                    crc16  <= crc16_step(crc16, dsr[63]);
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(63)) begin
                        // Fold in the last data bit while loading the CRC shifter.
                        state  <= S_RD_CRC;
                        cnt    <= '0;
                        crc_sr <= crc16_step(crc16, dsr[63]);
                    end
                end

                S_RD_CRC: begin
                    miso_q <= crc_sr[15];
                    crc_sr <= {crc_sr[14:0], 1'b0};
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(15)) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                end

                S_WR_WAIT: begin
                    miso_q <= 1'b1;
                    if (!bus.mosi) begin
                        state <= S_WR_DATA;
                        cnt   <= '0;
                        crc16 <= '0;
                    end else if (cnt == CNT_W'(TOKEN_TO - 1)) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_WR_DATA: begin
                    miso_q <= 1'b1;
                    dsr    <= {dsr[62:0], bus.mosi};
                    crc16  <= crc16_step(crc16, bus.mosi);
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(63)) begin
                        state <= S_WR_CRC;
                        cnt   <= '0;
                    end
                end

                S_WR_CRC: begin
                    miso_q <= 1'b1;
                    crc_sr <= {crc_sr[14:0], bus.mosi};
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(15)) begin
                        state   <= S_WR_RESP;
                        cnt     <= '0;
                        wr_ok   <= ({crc_sr[14:0], bus.mosi} == crc16);
                        tx_byte <= ({crc_sr[14:0], bus.mosi} == crc16) ? 8'h05 : 8'h0B;
                    end
                end

                S_WR_RESP: begin
                    miso_q  <= tx_byte[7];
                    tx_byte <= {tx_byte[6:0], 1'b1};
                    if ((cnt == '0) && wr_ok) begin
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= dsr;
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(7)) begin
                        state <= S_WR_BUSY;
                        cnt   <= '0;
                    end
                end

                S_WR_BUSY: begin
                    miso_q <= 1'b0;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(8 * BUSY_BYTES - 1)) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    cnt    <= '0;
                    miso_q <= 1'b1;
                end
            endcase
        end
    end

endmodule
